// File: rtl/ct_split_if.sv
// Stream bundle for the packet splitter: one valid/ready/eop input stream
// plus NO registered output streams and a drop indication.
interface ct_split_if #(
    parameter int NO    = 2,
    parameter int WIDTH = 1
);
    logic [WIDTH-1:0]    i_data;
    logic                i_valid;
    logic                o_ready;
    logic                i_eop;
    logic [NO-1:0]       i_mask;
    logic [NO*WIDTH-1:0] o_data;
    logic [NO-1:0]       o_valid;
    logic [NO-1:0]       o_eop;
    logic [NO-1:0]       i_ready;
    logic                o_drop;

    // Upstream source plus downstream sinks (the environment around the splitter).
    modport master (
        output i_data, i_valid, i_eop, i_mask, i_ready,
        input  o_ready, o_data, o_valid, o_eop, o_drop
    );

    // The splitter itself.
    modport slave (
        input  i_data, i_valid, i_eop, i_mask, i_ready,
        output o_ready, o_data, o_valid, o_eop, o_drop
    );
endinterface

// File: rtl/ct_split.sv
// Packet-aware splitter/multicaster. Each packet is routed to the outputs
// selected by the mask seen on its first beat; a beat is delivered to all of
// its outputs in the same cycle or not at all. Every output has a one-beat
// register, so latency is one cycle and throughput is one beat per cycle.
module ct_split #(
    parameter int NO    = 2,
    parameter int WIDTH = 1
) (
    input  logic        clk,
    input  logic        reset,
    ct_split_if.slave   bus
);

    logic          in_pkt;    // a packet is open; the next beat is not SOP
    logic [NO-1:0] route;     // destination mask latched at SOP
    logic [NO-1:0] eff_mask;  // destinations of the beat currently offered
    logic [NO-1:0] free;      // output register can take a beat this cycle
    logic [NO-1:0] load;      // outputs written by an accepted beat
    logic          accept;

    // At SOP the live mask steers the beat; afterwards the latched route does.
    assign eff_mask = in_pkt ? route : bus.i_mask;

    // An output is free when empty or being drained this same cycle.
    assign free = ~bus.o_valid | bus.i_ready;

    // Accept only when every destination is free; an empty mask is always ready.
    assign bus.o_ready = &(free | ~eff_mask);
    assign accept      = bus.i_valid && bus.o_ready;
    assign load        = accept ? eff_mask : '0;

    // Packet framing: latch the route on SOP, close the packet on eop.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            in_pkt <= 1'b0;
            route  <= '0;
        end else if (accept) begin
            // NOTE: non-blocking assignments make every register sample pre-edge values.
            if (!in_pkt) route <= bus.i_mask;
            in_pkt <= !bus.i_eop;
        end
    end

    // Output occupancy (load wins over drain) and the zero-mask drop pulse.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bus.o_valid <= '0;
            bus.o_drop  <= 1'b0;
        end else begin
            bus.o_valid <= load | (bus.o_valid & ~bus.i_ready);
            bus.o_drop  <= accept && (eff_mask == '0) && bus.i_eop;
        end
    end

    // Output payload registers; contents only matter while o_valid is set.
    always_ff @(posedge clk) begin
        // NOTE: payload registers carry no reset; o_valid qualifies them.
        for (int j = 0; j < NO; j++) begin
            if (load[j]) begin
                bus.o_data[WIDTH*j +: WIDTH] <= bus.i_data;
                bus.o_eop[j]                 <= bus.i_eop;
            end
        end
    end

endmodule

// File: tb/tb_ct_split.sv
// Self-checking bench for ct_split (NO=4, WIDTH=8). A transaction-level
// model (one expected-beat queue per output plus packet route state) is
// compared with the DUT on every falling edge; directed tests add literal
// expectations on the beats actually delivered by each output.
module tb_ct_split;

    localparam int NO    = 4;
    localparam int WIDTH = 8;

    logic clk;
    logic reset;

    ct_split_if #(.NO(NO), .WIDTH(WIDTH)) bus ();

    ct_split #(.NO(NO), .WIDTH(WIDTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks;
    int n_err;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- model ----------------
    logic [WIDTH:0] mq[NO][$];   // expected beats {eop,data} held per output
    logic [WIDTH:0] lg[NO][$];   // beats observed leaving each DUT output
    logic           m_in_pkt;
    logic [NO-1:0]  m_route;
    logic           m_drop;
    logic [NO-1:0]  m_mask;
    logic           m_rdy;
    int             drop_cnt;
    int             vcnt;

    always @(negedge clk) begin
        if (!reset) begin
            for (int j = 0; j < NO; j++) mq[j].delete();
            m_in_pkt = 1'b0;
            m_route  = '0;
            m_drop   = 1'b0;
        end else begin
            for (int j = 0; j < NO; j++) begin
                check($sformatf("o_valid[%0d]", j), 32'(bus.o_valid[j]), 32'(mq[j].size() != 0));
                if (mq[j].size() != 0) begin
                    check($sformatf("o_data[%0d]", j), 32'(bus.o_data[WIDTH*j +: WIDTH]),
                          32'(mq[j][0][WIDTH-1:0]));
                    check($sformatf("o_eop[%0d]", j), 32'(bus.o_eop[j]), 32'(mq[j][0][WIDTH]));
                end
            end
            check("o_drop", 32'(bus.o_drop), 32'(m_drop));
            if (bus.o_drop) drop_cnt++;
            if (|bus.o_valid) vcnt++;

            m_mask = m_in_pkt ? m_route : bus.i_mask;
            m_rdy  = 1'b1;
            for (int j = 0; j < NO; j++)
                if (m_mask[j] && mq[j].size() != 0 && !bus.i_ready[j]) m_rdy = 1'b0;
            check("o_ready", 32'(bus.o_ready), 32'(m_rdy));

            // Advance the model across the coming rising edge.
            for (int j = 0; j < NO; j++) begin
                if (bus.o_valid[j] && bus.i_ready[j])
                    lg[j].push_back({bus.o_eop[j], bus.o_data[WIDTH*j +: WIDTH]});
                if (mq[j].size() != 0 && bus.i_ready[j]) void'(mq[j].pop_front());
            end
            m_drop = 1'b0;
            if (bus.i_valid && m_rdy) begin
                for (int j = 0; j < NO; j++)
                    if (m_mask[j]) mq[j].push_back({bus.i_eop, bus.i_data});
                if (m_mask == '0 && bus.i_eop) m_drop = 1'b1;
                if (!m_in_pkt) m_route = bus.i_mask;
                m_in_pkt = !bus.i_eop;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic clear_logs();
        for (int j = 0; j < NO; j++) lg[j].delete();
        drop_cnt = 0;
        vcnt     = 0;
    endtask

    // Offer one beat until accepted (bounded); returns cycles spent waiting.
    task automatic send(input logic [WIDTH-1:0] d, input logic e, input logic [NO-1:0] m,
                        output int waited);
        logic r;
        r = 1'b0;
        waited = 0;
        bus.i_data  = d;
        bus.i_eop   = e;
        bus.i_mask  = m;
        bus.i_valid = 1'b1;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            r = bus.o_ready;
            @(posedge clk);
            #1;
            if (r) break;
            waited++;
        end
        if (!r) check("send_timeout", 32'(r), 32'd1);
        bus.i_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_log(input string name, input int j, input int idx,
                             input logic [WIDTH-1:0] d, input logic e);
        if (lg[j].size() > idx) begin
            check({name, "_data"}, 32'(lg[j][idx][WIDTH-1:0]), 32'(d));
            check({name, "_eop"}, 32'(lg[j][idx][WIDTH]), 32'(e));
        end else begin
            check({name, "_missing"}, 32'(lg[j].size()), 32'(idx + 1));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    int w;

    initial begin
        n_checks = 0;
        n_err    = 0;
        clear_logs();
        reset       = 1'b0;
        bus.i_data  = '0;
        bus.i_eop   = 1'b0;
        bus.i_mask  = '0;
        bus.i_valid = 1'b0;
        bus.i_ready = '1;

        // Reset state
        idle(2);
        check("rst_o_valid", 32'(bus.o_valid), 32'd0);
        check("rst_o_drop", 32'(bus.o_drop), 32'd0);
        reset = 1'b1;
        idle(1);

        // T1: 3-beat packet to output 2
        clear_logs();
        send(8'h0A, 1'b0, 4'b0100, w);
        check("t1_wait0", 32'(w), 32'd0);
        send(8'h0B, 1'b0, 4'b0100, w);
        send(8'h0C, 1'b1, 4'b0100, w);
        idle(3);
        check("t1_cnt2", 32'(lg[2].size()), 32'd3);
        check_log("t1_b0", 2, 0, 8'h0A, 1'b0);
        check_log("t1_b1", 2, 1, 8'h0B, 1'b0);
        check_log("t1_b2", 2, 2, 8'h0C, 1'b1);
        check("t1_others", 32'(lg[0].size() + lg[1].size() + lg[3].size()), 32'd0);

        // T2: multicast 1010, output 3 stalls for 2 cycles holding beat 1
        clear_logs();
        send(8'h11, 1'b0, 4'b1010, w);
        send(8'h22, 1'b0, 4'b1010, w);
        bus.i_ready = 4'b0111;
        bus.i_data  = 8'h33;
        bus.i_eop   = 1'b1;
        bus.i_valid = 1'b1;
        @(negedge clk);
        check("t2_stall_a", 32'(bus.o_ready), 32'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("t2_stall_b", 32'(bus.o_ready), 32'd0);
        check("t2_hold3", 32'(bus.o_data[WIDTH*3 +: WIDTH]), 32'h22);
        @(posedge clk);
        #1;
        bus.i_ready = '1;
        @(negedge clk);
        check("t2_release", 32'(bus.o_ready), 32'd1);
        @(posedge clk);
        #1;
        bus.i_valid = 1'b0;
        idle(3);
        check("t2_cnt1", 32'(lg[1].size()), 32'd3);
        check("t2_cnt3", 32'(lg[3].size()), 32'd3);
        check_log("t2_o1b1", 1, 1, 8'h22, 1'b0);
        check_log("t2_o1b2", 1, 2, 8'h33, 1'b1);
        check_log("t2_o3b1", 3, 1, 8'h22, 1'b0);
        check_log("t2_o3b2", 3, 2, 8'h33, 1'b1);

        // T3: mask change mid-packet is ignored
        clear_logs();
        send(8'h41, 1'b0, 4'b0010, w);
        send(8'h42, 1'b0, 4'b0001, w);
        send(8'h43, 1'b1, 4'b0001, w);
        idle(3);
        check("t3_cnt1", 32'(lg[1].size()), 32'd3);
        check("t3_cnt0", 32'(lg[0].size()), 32'd0);
        check_log("t3_b2", 1, 2, 8'h43, 1'b1);

        // T4: zero-mask 2-beat packet is dropped
        clear_logs();
        send(8'h51, 1'b0, 4'b0000, w);
        check("t4_ready_b0", 32'(w), 32'd0);
        send(8'h52, 1'b1, 4'b0000, w);
        check("t4_ready_b1", 32'(w), 32'd0);
        idle(3);
        check("t4_drops", 32'(drop_cnt), 32'd1);
        check("t4_no_valid", 32'(vcnt), 32'd0);

        // T5: back-to-back single-beat packets to 0,1,0,1
        clear_logs();
        send(8'h61, 1'b1, 4'b0001, w);
        check("t5_w0", 32'(w), 32'd0);
        send(8'h62, 1'b1, 4'b0010, w);
        check("t5_w1", 32'(w), 32'd0);
        send(8'h63, 1'b1, 4'b0001, w);
        check("t5_w2", 32'(w), 32'd0);
        send(8'h64, 1'b1, 4'b0010, w);
        check("t5_w3", 32'(w), 32'd0);
        idle(3);
        check_log("t5_o0a", 0, 0, 8'h61, 1'b1);
        check_log("t5_o0b", 0, 1, 8'h63, 1'b1);
        check_log("t5_o1a", 1, 0, 8'h62, 1'b1);
        check_log("t5_o1b", 1, 1, 8'h64, 1'b1);

        // T6: reset mid-packet, then a new SOP picks a new route
        clear_logs();
        send(8'h71, 1'b0, 4'b0100, w);
        #3;
        reset = 1'b0;
        #1;
        check("t6_async_valid", 32'(bus.o_valid), 32'd0);
        idle(2);
        reset = 1'b1;
        idle(1);
        send(8'h77, 1'b1, 4'b0001, w);
        idle(3);
        check("t6_cnt2", 32'(lg[2].size()), 32'd0);
        check("t6_cnt0", 32'(lg[0].size()), 32'd1);
        check_log("t6_o0", 0, 0, 8'h77, 1'b1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
